// File: rtl/csr_trap_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | csr_trap_ctrl_if : core request, fetch redirect and CSR-file port bundle |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface csr_trap_ctrl_if;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        csr_req;
  logic [1:0]  csr_op;
  logic [11:0] csr_num;
  logic [31:0] csr_wdata;
  logic        csr_ack;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        busy;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;
  logic [11:0] csr_addr1;
  logic [11:0] csr_addr2;
  logic [11:0] csr_addr3;
  logic        csr_we1;
  logic        csr_we2;
  logic        csr_we3;
  logic [31:0] csr_wd1;
  logic [31:0] csr_wd2;
  logic [31:0] csr_wd3;
  logic [31:0] csr_rd1;
  logic [31:0] csr_rd2;
  logic [31:0] csr_rd3;

  // Environment side: core, fetch stage and CSR file.
  modport master (
    output trap_valid, trap_cause, trap_pc, trap_tval, mret_valid,
    output csr_req, csr_op, csr_num, csr_wdata, redir_ready,
    output csr_rd1, csr_rd2, csr_rd3,
    input  csr_ack, csr_rdata, csr_illegal, busy, redir_valid, redir_pc,
    input  csr_addr1, csr_addr2, csr_addr3, csr_we1, csr_we2, csr_we3,
    input  csr_wd1, csr_wd2, csr_wd3
  );

  modport slave (
    input  trap_valid, trap_cause, trap_pc, trap_tval, mret_valid,
    input  csr_req, csr_op, csr_num, csr_wdata, redir_ready,
    input  csr_rd1, csr_rd2, csr_rd3,
    output csr_ack, csr_rdata, csr_illegal, busy, redir_valid, redir_pc,
    output csr_addr1, csr_addr2, csr_addr3, csr_we1, csr_we2, csr_we3,
    output csr_wd1, csr_wd2, csr_wd3
  );
endinterface

`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
// +--------------------------------------------------------------------------+
// | csr_trap_ctrl : machine CSR sequencer for init, CSR ops, trap and mret  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module csr_trap_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
  input  wire logic         clk,
  input  wire logic         rst,
  csr_trap_ctrl_if.slave    bus_io
);

  localparam logic [2:0] IDX_MSTATUS = 3'd0;
  localparam logic [2:0] IDX_MTVEC   = 3'd1;
  localparam logic [2:0] IDX_MEPC    = 3'd2;
  localparam logic [2:0] IDX_MCAUSE  = 3'd3;
  localparam logic [2:0] IDX_MTVAL   = 3'd4;

  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  typedef enum logic [2:0] {
    INIT0     = 3'd0,
    INIT1     = 3'd1,
    IDLE      = 3'd2,
    CSR_RW    = 3'd3,
    TRAP_SAVE = 3'd4,
    TRAP_STAT = 3'd5,
    MRET_STAT = 3'd6,
    REDIR     = 3'd7
  } state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [11:0]     num_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] redir_pc_q;

  logic [3:0]      w_map;
  logic            w_legal;
  logic [2:0]      w_idx;
  logic [XLEN-1:0] w_mstatus_trap;
  logic [XLEN-1:0] w_mstatus_mret;

  // Returns {legal, index}; unmapped numbers come back with legal=0.
  function automatic logic [3:0] csr_map(input logic [11:0] num);
    case (num)
      12'h300: csr_map = {1'b1, IDX_MSTATUS};
      12'h305: csr_map = {1'b1, IDX_MTVEC};
      12'h341: csr_map = {1'b1, IDX_MEPC};
      12'h342: csr_map = {1'b1, IDX_MCAUSE};
      12'h343: csr_map = {1'b1, IDX_MTVAL};
      default: csr_map = 4'd0;
    endcase
  endfunction

  assign w_map   = csr_map(num_q);
  assign w_legal = w_map[3];
  assign w_idx   = w_map[2:0];

  always_comb begin
    w_mstatus_trap        = bus_io.csr_rd1;
    w_mstatus_trap[7]     = bus_io.csr_rd1[3];
    w_mstatus_trap[3]     = 1'b0;
    w_mstatus_trap[12:11] = 2'b11;

    w_mstatus_mret        = bus_io.csr_rd1;
    w_mstatus_mret[3]     = bus_io.csr_rd1[7];
    w_mstatus_mret[7]     = 1'b1;
    w_mstatus_mret[12:11] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT0;
      op_q       <= '0;
      num_q      <= '0;
      wdata_q    <= '0;
      cause_q    <= '0;
      pc_q       <= '0;
      tval_q     <= '0;
      redir_pc_q <= '0;
    end else begin
      case (state_q)
        INIT0: state_q <= INIT1;
        INIT1: state_q <= IDLE;
        IDLE: begin
          if (bus_io.trap_valid) begin
            cause_q <= bus_io.trap_cause;
            pc_q    <= bus_io.trap_pc;
            tval_q  <= bus_io.trap_tval;
            state_q <= TRAP_SAVE;
          end else if (bus_io.mret_valid) begin
            state_q <= MRET_STAT;
          end else if (bus_io.csr_req) begin
            op_q    <= bus_io.csr_op;
            num_q   <= bus_io.csr_num;
            wdata_q <= bus_io.csr_wdata;
            state_q <= CSR_RW;
          end
        end
        CSR_RW:    state_q <= IDLE;
        TRAP_SAVE: state_q <= TRAP_STAT;
        // Only direct-mode mtvec is supported, so the mode bits are dropped.
        TRAP_STAT, MRET_STAT: begin
          redir_pc_q <= bus_io.csr_rd2 & ALIGN_MASK;
          state_q    <= REDIR;
        end
        REDIR: begin
          if (bus_io.redir_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= INIT0;
      endcase
    end
  end

  always_comb begin
    bus_io.csr_addr1 = '0;
    bus_io.csr_addr2 = '0;
    bus_io.csr_addr3 = '0;
    bus_io.csr_we1   = 1'b0;
    bus_io.csr_we2   = 1'b0;
    bus_io.csr_we3   = 1'b0;
    bus_io.csr_wd1   = '0;
    bus_io.csr_wd2   = '0;
    bus_io.csr_wd3   = '0;
    case (state_q)
      INIT0: begin
        bus_io.csr_addr1 = {9'd0, IDX_MSTATUS};
        bus_io.csr_addr2 = {9'd0, IDX_MTVEC};
        bus_io.csr_addr3 = {9'd0, IDX_MEPC};
        bus_io.csr_wd2   = MTVEC_RESET;
        bus_io.csr_we1   = 1'b1;
        bus_io.csr_we2   = 1'b1;
        bus_io.csr_we3   = 1'b1;
      end
      INIT1: begin
        bus_io.csr_addr1 = {9'd0, IDX_MCAUSE};
        bus_io.csr_addr2 = {9'd0, IDX_MTVAL};
        bus_io.csr_we1   = 1'b1;
        bus_io.csr_we2   = 1'b1;
      end
      CSR_RW: begin
        bus_io.csr_addr1 = {9'd0, w_idx};
        if (w_legal) begin
          case (op_q)
            OP_RS: begin
              bus_io.csr_wd1 = bus_io.csr_rd1 | wdata_q;
              bus_io.csr_we1 = (wdata_q != '0);
            end
            OP_RC: begin
              bus_io.csr_wd1 = bus_io.csr_rd1 & ~wdata_q;
              bus_io.csr_we1 = (wdata_q != '0);
            end
            default: begin
              bus_io.csr_wd1 = wdata_q;
              bus_io.csr_we1 = 1'b1;
            end
          endcase
        end
      end
      TRAP_SAVE: begin
        bus_io.csr_addr1 = {9'd0, IDX_MEPC};
        bus_io.csr_addr2 = {9'd0, IDX_MCAUSE};
        bus_io.csr_addr3 = {9'd0, IDX_MTVAL};
        bus_io.csr_wd1   = pc_q & ALIGN_MASK;
        bus_io.csr_wd2   = cause_q;
        bus_io.csr_wd3   = tval_q;
        bus_io.csr_we1   = 1'b1;
        bus_io.csr_we2   = 1'b1;
        bus_io.csr_we3   = 1'b1;
      end
      TRAP_STAT: begin
        bus_io.csr_addr1 = {9'd0, IDX_MSTATUS};
        bus_io.csr_addr2 = {9'd0, IDX_MTVEC};
        bus_io.csr_wd1   = w_mstatus_trap;
        bus_io.csr_we1   = 1'b1;
      end
      MRET_STAT: begin
        bus_io.csr_addr1 = {9'd0, IDX_MSTATUS};
        bus_io.csr_addr2 = {9'd0, IDX_MEPC};
        bus_io.csr_wd1   = w_mstatus_mret;
        bus_io.csr_we1   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_io.csr_ack     = (state_q == CSR_RW);
  assign bus_io.csr_illegal = (state_q == CSR_RW) && !w_legal;
  assign bus_io.csr_rdata   = ((state_q == CSR_RW) && w_legal) ? bus_io.csr_rd1 : '0;
  assign bus_io.busy        = (state_q != IDLE);
  assign bus_io.redir_valid = (state_q == REDIR);
  assign bus_io.redir_pc    = redir_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_csr_trap_ctrl : directed bench with a 5-entry CSR file model         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_csr_trap_ctrl;

  logic clk;
  logic rst;
  logic poke;
  int   n_checks;
  int   n_fail;

  logic [31:0] file_q [0:4];

  csr_trap_ctrl_if bus ();

  csr_trap_ctrl #(
    .XLEN        (32),
    .MTVEC_RESET (32'h0000_0100)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file: no reset, higher port wins, poke fills it with garbage.
  always @(posedge clk) begin
    if (poke) begin
      for (int k = 0; k < 5; k++) file_q[k] <= 32'hBAD0_0000 | 32'(k);
    end else begin
      if (bus.csr_we1 && bus.csr_addr1 < 12'd5) file_q[bus.csr_addr1[2:0]] <= bus.csr_wd1;
      if (bus.csr_we2 && bus.csr_addr2 < 12'd5) file_q[bus.csr_addr2[2:0]] <= bus.csr_wd2;
      if (bus.csr_we3 && bus.csr_addr3 < 12'd5) file_q[bus.csr_addr3[2:0]] <= bus.csr_wd3;
    end
  end

  assign bus.csr_rd1 = (bus.csr_addr1 < 12'd5) ? file_q[bus.csr_addr1[2:0]] : 32'h0;
  assign bus.csr_rd2 = (bus.csr_addr2 < 12'd5) ? file_q[bus.csr_addr2[2:0]] : 32'h0;
  assign bus.csr_rd3 = (bus.csr_addr3 < 12'd5) ? file_q[bus.csr_addr3[2:0]] : 32'h0;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] num;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
    logic        exp_we;
    int          chk_idx;
    logic [31:0] exp_val;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{2'b01, 12'h343, 32'h0000_00A5, 32'h0,         1'b0, 1'b1, 4, 32'h0000_00A5};
    vecs[1]  = '{2'b10, 12'h343, 32'h0000_000F, 32'h0000_00A5, 1'b0, 1'b1, 4, 32'h0000_00AF};
    vecs[2]  = '{2'b11, 12'h343, 32'h0000_00A0, 32'h0000_00AF, 1'b0, 1'b1, 4, 32'h0000_000F};
    vecs[3]  = '{2'b10, 12'h343, 32'h0,         32'h0000_000F, 1'b0, 1'b0, 4, 32'h0000_000F};
    vecs[4]  = '{2'b11, 12'h343, 32'h0,         32'h0000_000F, 1'b0, 1'b0, 4, 32'h0000_000F};
    vecs[5]  = '{2'b00, 12'h343, 32'h1234_5678, 32'h0000_000F, 1'b0, 1'b1, 4, 32'h1234_5678};
    vecs[6]  = '{2'b01, 12'h7C0, 32'h0000_FFFF, 32'h0,         1'b1, 1'b0, 4, 32'h1234_5678};
    vecs[7]  = '{2'b01, 12'h300, 32'h0000_0008, 32'h0,         1'b0, 1'b1, 0, 32'h0000_0008};
    vecs[8]  = '{2'b01, 12'h341, 32'h0000_5555, 32'h0,         1'b0, 1'b1, 2, 32'h0000_5555};
    vecs[9]  = '{2'b10, 12'h305, 32'h0,         32'h0000_0100, 1'b0, 1'b0, 1, 32'h0000_0100};
    vecs[10] = '{2'b01, 12'h342, 32'h0000_0007, 32'h0,         1'b0, 1'b1, 3, 32'h0000_0007};
    vecs[11] = '{2'b11, 12'h301, 32'h0000_00FF, 32'h0,         1'b1, 1'b0, 3, 32'h0000_0007};

    rst = 1'b1;
    poke = 1'b1;
    bus.trap_valid = 1'b0; bus.trap_cause = '0; bus.trap_pc = '0; bus.trap_tval = '0;
    bus.mret_valid = 1'b0; bus.csr_req = 1'b0; bus.csr_op = '0; bus.csr_num = '0;
    bus.csr_wdata = '0; bus.redir_ready = 1'b0;

    // Reset and init sequence
    tick();
    rst = 1'b0;
    poke = 1'b0;
    chk("init0_busy", 32'(bus.busy), 32'h1);
    chk("init0_we", {29'd0, bus.csr_we1, bus.csr_we2, bus.csr_we3}, 32'h7);
    chk("init0_wd2", bus.csr_wd2, 32'h100);
    chk("init0_addr3", 32'(bus.csr_addr3), 32'h2);
    tick();
    chk("init1_busy", 32'(bus.busy), 32'h1);
    chk("init1_we", {29'd0, bus.csr_we1, bus.csr_we2, bus.csr_we3}, 32'h6);
    chk("init1_addr", {bus.csr_addr1[15:0] , bus.csr_addr2[15:0]}, {16'd3, 16'd4});
    tick();
    chk("idle_busy", 32'(bus.busy), 32'h0);
    chk("init_mstatus", file_q[0], 32'h0);
    chk("init_mtvec", file_q[1], 32'h100);
    chk("init_mepc", file_q[2], 32'h0);
    chk("init_mcause", file_q[3], 32'h0);
    chk("init_mtval", file_q[4], 32'h0);

    // Table-driven CSR instructions
    for (int i = 0; i < NV; i++) begin
      bus.csr_req = 1'b1;
      bus.csr_op = vecs[i].op;
      bus.csr_num = vecs[i].num;
      bus.csr_wdata = vecs[i].wdata;
      tick();
      bus.csr_req = 1'b0;
      bus.csr_num = 12'h343;
      bus.csr_wdata = 32'hFFFF_FFFF;
      chk($sformatf("vec%0d_ack", i), 32'(bus.csr_ack), 32'h1);
      chk($sformatf("vec%0d_rdata", i), bus.csr_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_illegal", i), 32'(bus.csr_illegal), 32'(vecs[i].exp_ill));
      chk($sformatf("vec%0d_we", i), {29'd0, bus.csr_we1, bus.csr_we2, bus.csr_we3},
          {29'd0, vecs[i].exp_we, 2'b00});
      tick();
      chk($sformatf("vec%0d_ack_low", i), {30'd0, bus.csr_ack, bus.busy}, 32'h0);
      chk($sformatf("vec%0d_file", i), file_q[vecs[i].chk_idx], vecs[i].exp_val);
    end

    // Trap with mret and csr_req competing; losers keep holding
    bus.trap_valid = 1'b1; bus.trap_cause = 32'h2; bus.trap_pc = 32'h1236;
    bus.trap_tval = 32'hDEAD; bus.mret_valid = 1'b1;
    bus.csr_req = 1'b1; bus.csr_op = 2'b01; bus.csr_num = 12'h342; bus.csr_wdata = 32'h77;
    tick();
    bus.trap_valid = 1'b0; bus.trap_cause = 32'hFFFF; bus.trap_pc = 32'hFFFF; bus.trap_tval = 32'hFFFF;
    chk("tsave_ack", 32'(bus.csr_ack), 32'h0);
    chk("tsave_we", {29'd0, bus.csr_we1, bus.csr_we2, bus.csr_we3}, 32'h7);
    chk("tsave_wd1", bus.csr_wd1, 32'h1234);
    chk("tsave_wd2", bus.csr_wd2, 32'h2);
    chk("tsave_wd3", bus.csr_wd3, 32'hDEAD);
    tick();
    chk("tstat_redir_valid", 32'(bus.redir_valid), 32'h0);
    chk("tstat_mepc", file_q[2], 32'h1234);
    chk("tstat_mcause", file_q[3], 32'h2);
    chk("tstat_mtval", file_q[4], 32'hDEAD);
    chk("tstat_wd1", bus.csr_wd1, 32'h1880);
    chk("tstat_ack", 32'(bus.csr_ack), 32'h0);
    tick();
    chk("trap_redir_valid", 32'(bus.redir_valid), 32'h1);
    chk("trap_redir_pc", bus.redir_pc, 32'h100);
    chk("trap_mstatus", file_q[0], 32'h1880);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("trap_hold%0d_valid", j), 32'(bus.redir_valid), 32'h1);
      chk($sformatf("trap_hold%0d_pc", j), bus.redir_pc, 32'h100);
      chk($sformatf("trap_hold%0d_ack", j), 32'(bus.csr_ack), 32'h0);
    end
    bus.redir_ready = 1'b1;
    tick();
    bus.redir_ready = 1'b0;
    chk("trap_done_valid", 32'(bus.redir_valid), 32'h0);
    chk("trap_done_busy", 32'(bus.busy), 32'h0);
    chk("trap_done_pc", bus.redir_pc, 32'h100);

    // mret wins over the still-held csr_req
    tick();
    bus.mret_valid = 1'b0;
    chk("mstat_ack", 32'(bus.csr_ack), 32'h0);
    chk("mstat_wd1", bus.csr_wd1, 32'h1888);
    chk("mstat_we", {29'd0, bus.csr_we1, bus.csr_we2, bus.csr_we3}, 32'h4);
    tick();
    chk("mret_redir_valid", 32'(bus.redir_valid), 32'h1);
    chk("mret_redir_pc", bus.redir_pc, 32'h1234);
    chk("mret_mstatus", file_q[0], 32'h1888);
    bus.redir_ready = 1'b1;
    tick();
    bus.redir_ready = 1'b0;
    chk("mret_done_valid", 32'(bus.redir_valid), 32'h0);
    tick();
    bus.csr_req = 1'b0;
    chk("held_csr_ack", 32'(bus.csr_ack), 32'h1);
    chk("held_csr_rdata", bus.csr_rdata, 32'h2);
    tick();
    chk("held_csr_mcause", file_q[3], 32'h77);

    // Reset asserted in TRAP_STAT
    bus.trap_valid = 1'b1; bus.trap_cause = 32'h5; bus.trap_pc = 32'h2000; bus.trap_tval = 32'h1;
    tick();
    bus.trap_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'h1);
    chk("rst_redir_valid", 32'(bus.redir_valid), 32'h0);
    chk("rst_redir_pc", bus.redir_pc, 32'h0);
    chk("rst_init0_we", {29'd0, bus.csr_we1, bus.csr_we2, bus.csr_we3}, 32'h7);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("rst_post%0d_valid", j), 32'(bus.redir_valid), 32'h0);
    end
    chk("rst_post_busy", 32'(bus.busy), 32'h0);
    chk("rst_post_mstatus", file_q[0], 32'h0);
    chk("rst_post_mepc", file_q[2], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
